// File: rtl/gru_pkg.sv
// Shared fixed-point definitions for the GRU datapath stages (Q2.14 signed).
package gru_pkg;

  localparam int DATA_W = 16;
  localparam int FRAC_W = 14;
  // Wide accumulator used for round/saturate of products and sums.
  localparam int ACC_W  = 36;

  localparam logic [DATA_W-1:0] Q_ONE = 16'h4000;
  localparam logic [DATA_W-1:0] Q_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] Q_MIN = 16'h8000;

  localparam logic signed [ACC_W-1:0] HALF_LSB = 36'sh0_0000_2000;
  localparam logic signed [ACC_W-1:0] SAT_HI   = 36'sh0_0000_7FFF;
  localparam logic signed [ACC_W-1:0] SAT_LO   = 36'shF_FFFF_8000;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } hs_state_t;

  // Drop FRAC_W fraction bits, rounding half up (floor of value + 0.5 LSB).
  function automatic logic signed [ACC_W-1:0] round_shr(input logic signed [ACC_W-1:0] v);
    return (v + HALF_LSB) >>> FRAC_W;
  endfunction

  // Clamp a wide value into the Q2.14 range.
  function automatic logic signed [DATA_W-1:0] sat_q(input logic signed [ACC_W-1:0] v);
    if (v > SAT_HI)      return Q_MAX;
    else if (v < SAT_LO) return Q_MIN;
    else                 return v[DATA_W-1:0];
  endfunction

endpackage

// File: rtl/gru_hupd_dp.sv
// Three-stage h update datapath: diff, multiply by z, round/saturate and add n.
// Index and valid travel alongside the data; kill drops every in-flight beat.
module gru_hupd_dp
  import gru_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     kill,
  input  logic                     in_vld,
  input  logic [IDX_W-1:0]         in_idx,
  input  logic signed [DATA_W-1:0] h_prev,
  input  logic signed [DATA_W-1:0] z_in,
  input  logic signed [DATA_W-1:0] n_in,
  output logic                     wr_en,
  output logic [IDX_W-1:0]         wr_idx,
  output logic signed [DATA_W-1:0] wr_data,
  output logic [DATA_W-1:0]        out_h,
  output logic [IDX_W-1:0]         out_idx,
  output logic                     out_vld
);

  logic                     vld_p1, vld_p2;
  logic [IDX_W-1:0]         idx_p1, idx_p2;
  logic signed [DATA_W:0]   diff_p1;
  logic signed [DATA_W-1:0] z_p1, n_p1, n_p2;
  logic signed [32:0]       prod_p2;
  logic signed [ACC_W-1:0]  acc_p2;

  // Valid sideband: cleared on reset and by kill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
      vld_p2 <= 1'b0;
    end else begin
      vld_p1 <= in_vld & ~kill;
      vld_p2 <= vld_p1 & ~kill;
    end
  end

  // S1 -> p1: h_prev - n in 17 bits; S2 -> p2: z * diff in 33 bits.
  always_ff @(posedge clk) begin
    diff_p1 <= 17'(h_prev) - 17'(n_in);
    z_p1    <= z_in;
    n_p1    <= n_in;
    idx_p1  <= in_idx;
    prod_p2 <= 33'(z_p1) * 33'(diff_p1);
    n_p2    <= n_p1;
    idx_p2  <= idx_p1;
  end

  // S3: round the product, add n, saturate.
  always_comb begin
    acc_p2  = round_shr(ACC_W'(prod_p2)) + ACC_W'(n_p2);
    wr_data = sat_q(acc_p2);
    wr_en   = vld_p2 & ~kill;
    wr_idx  = idx_p2;
  end

  // Registered result port; data holds between strobes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_vld <= 1'b0;
      out_h   <= '0;
      out_idx <= '0;
    end else begin
      out_vld <= wr_en;
      if (wr_en) begin
        out_h   <= wr_data;
        out_idx <= wr_idx;
      end
    end
  end

endmodule

// File: rtl/gru_hstate_update.sv
// GRU hidden-state update: h_t = n + z*(h_prev - n), owning the hidden-state file.
// Elements arrive in index order; seq_start sweeps the file to zero over HIDDEN_SIZE cycles.
module gru_hstate_update
  import gru_pkg::*;
#(
  parameter  int HIDDEN_SIZE = 16,
  localparam int IDX_W       = $clog2(HIDDEN_SIZE)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              seq_start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [15:0]       z_in,
  input  logic [15:0]       n_in,
  output logic [15:0]       h_out,
  output logic [IDX_W-1:0]  h_out_idx,
  output logic              h_out_valid,
  output logic              step_done,
  input  logic [IDX_W-1:0]  rd_idx,
  output logic [15:0]       rd_data
);

  if (HIDDEN_SIZE < 4 || HIDDEN_SIZE > 256) begin : g_bad_size
    $error("gru_hstate_update: HIDDEN_SIZE must be in 4..256");
  end

  localparam logic [IDX_W-1:0] LAST = IDX_W'(HIDDEN_SIZE - 1);

  hs_state_t                 state;
  logic [IDX_W-1:0]          idx, clr_cnt;
  logic                      accept;
  logic signed [DATA_W-1:0]  h_prev;
  logic                      wr_en;
  logic [IDX_W-1:0]          wr_idx;
  logic signed [DATA_W-1:0]  wr_data;
  logic [DATA_W-1:0]         h_mem [HIDDEN_SIZE];

  // in_ready is high exactly in RUN, so it doubles as the state qualifier.
  assign accept = in_valid & in_ready & ~seq_start;
  assign h_prev = h_mem[idx];

  // Control FSM: RUN accepts beats in index order, CLEAR sweeps the file.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_RUN;
      idx      <= '0;
      clr_cnt  <= '0;
      in_ready <= 1'b1;
    end else if (seq_start) begin
      state    <= ST_CLEAR;
      idx      <= '0;
      clr_cnt  <= '0;
      in_ready <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (accept) idx <= (idx == LAST) ? '0 : idx + 1'b1;
        end
        ST_CLEAR: begin
          if (clr_cnt == LAST) begin
            state    <= ST_RUN;
            idx      <= '0;
            in_ready <= 1'b1;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        default: state <= ST_RUN;
      endcase
    end
  end

  gru_hupd_dp #(
    .IDX_W (IDX_W)
  ) u_dp (
    .clk     (clk),
    .rst_n   (rst_n),
    .kill    (seq_start),
    .in_vld  (accept),
    .in_idx  (idx),
    .h_prev  (h_prev),
    .z_in    ($signed(z_in)),
    .n_in    ($signed(n_in)),
    .wr_en   (wr_en),
    .wr_idx  (wr_idx),
    .wr_data (wr_data),
    .out_h   (h_out),
    .out_idx (h_out_idx),
    .out_vld (h_out_valid)
  );

  // Hidden-state file: zeroed by reset or by the CLEAR sweep, else written by S3.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < HIDDEN_SIZE; i++) h_mem[i] <= '0;
    end else if (state == ST_CLEAR && !seq_start) begin
      h_mem[clr_cnt] <= '0;
    end else if (wr_en) begin
      h_mem[wr_idx] <= wr_data;
    end
  end

  // End-of-step pulse aligned with the last element's result strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) step_done <= 1'b0;
    else        step_done <= wr_en && (wr_idx == LAST);
  end

  // Registered read port; a same-cycle write is not forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                           rd_data <= '0;
    else if (int'(rd_idx) < HIDDEN_SIZE)  rd_data <= h_mem[rd_idx];
    else                                  rd_data <= '0;
  end

endmodule
